// File: rtl/scarv_soc_intc_pkg.sv
// scarv_soc_intc_pkg: register map and shared constants for the SoC interrupt controller
package scarv_soc_intc_pkg;
  localparam logic [31:0] INTC_PENDING  = 32'h00;
  localparam logic [31:0] INTC_ENABLE   = 32'h04;
  localparam logic [31:0] INTC_MODE     = 32'h08;
  localparam logic [31:0] INTC_CLAIM    = 32'h0C;
  localparam logic [31:0] INTC_NO_CLAIM = 32'hFFFF_FFFF;
  localparam int          INTC_MAX_SRC  = 32;
endpackage

// File: rtl/scarv_soc_intc_prio.sv
// scarv_soc_intc_prio: lowest-index-wins priority encoder
module scarv_soc_intc_prio #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   index
);
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) index = 5'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/scarv_soc_intc.sv
// scarv_soc_intc: edge/level maskable interrupt aggregator with a memory-mapped claim register
module scarv_soc_intc
  import scarv_soc_intc_pkg::*;
#(
  parameter int                  NUM_SRC      = 8,
  parameter logic [NUM_SRC-1:0]  RESET_ENABLE = '0,
  parameter logic [NUM_SRC-1:0]  RESET_MODE   = '1
) (
  input  logic               f_clk,
  input  logic               g_reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               mem_req,
  output logic               mem_gnt,
  input  logic               mem_wen,
  input  logic [3:0]         mem_strb,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic               mem_recv,
  input  logic               mem_ack,
  output logic               mem_error,
  output logic [31:0]        mem_rdata,
  output logic               int_ext,
  output logic [31:0]        int_ext_cause
);
  localparam logic [NUM_SRC-1:0] ONE = 1;
  logic [NUM_SRC-1:0] src_q, pending, enable, mode, active, smask, wd, w1c, claim_clr, pend_n;
  logic [31:0] sel, lane, rdata_n;
  logic        accept, bad, wr, rd, valid;
  logic [4:0]  index;
  logic        unused;
  assign accept = mem_req & mem_gnt;
  assign mem_gnt = !mem_recv | mem_ack;
  assign sel = {27'd0, mem_addr[4:2], 2'd0};
  assign bad = mem_addr[4];
  assign wr = accept & mem_wen & !bad;
  assign rd = accept & !mem_wen & !bad;
  assign lane = {{8{mem_strb[3]}}, {8{mem_strb[2]}}, {8{mem_strb[1]}}, {8{mem_strb[0]}}};
  assign smask = lane[NUM_SRC-1:0];
  assign wd = mem_wdata[NUM_SRC-1:0];
  assign active = pending & enable;
  scarv_soc_intc_prio #(.N(NUM_SRC)) u_prio (
    .req   (active),
    .valid (valid),
    .index (index)
  );
  assign w1c = (wr && sel == INTC_PENDING) ? smask & wd : '0;
  assign claim_clr = (rd && sel == INTC_CLAIM && valid) ? ONE << index : '0;
  // a fresh edge always beats a clear; level sources just track the line
  assign pend_n = (mode & ((pending & ~w1c & ~claim_clr) | (src & ~src_q))) | (~mode & src);
  assign rdata_n = (bad || mem_wen) ? '0 :
                   sel == INTC_PENDING ? 32'(pending) :
                   sel == INTC_ENABLE  ? 32'(enable)  :
                   sel == INTC_MODE    ? 32'(mode)    :
                   valid               ? 32'(index)   : INTC_NO_CLAIM;
  assign unused = ^{mem_addr[31:5], mem_addr[1:0], mem_wdata, lane};
  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      src_q         <= '0;
      pending       <= '0;
      enable        <= RESET_ENABLE;
      mode          <= RESET_MODE;
      int_ext       <= 1'b0;
      int_ext_cause <= '0;
      mem_recv      <= 1'b0;
      mem_error     <= 1'b0;
      mem_rdata     <= '0;
    end else begin
      src_q         <= src;
      pending       <= pend_n;
      int_ext       <= |active;
      int_ext_cause <= 32'(index);
      if (wr && sel == INTC_ENABLE) enable <= (enable & ~smask) | (wd & smask);
      if (wr && sel == INTC_MODE) mode <= (mode & ~smask) | (wd & smask);
      if (accept) begin
        mem_recv  <= 1'b1;
        mem_error <= bad;
        mem_rdata <= rdata_n;
      end else if (mem_ack) begin
        mem_recv  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_scarv_soc_intc.sv
// tb_scarv_soc_intc: randomized scoreboard bench against a per-bit behavioural model
module tb_scarv_soc_intc;
  localparam int N = 8;
  logic f_clk = 0, g_reset = 1;
  logic [N-1:0] src = '0;
  logic mem_req = 0, mem_wen = 0, mem_ack = 1;
  logic [3:0] mem_strb = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic mem_gnt, mem_recv, mem_error, int_ext;
  logic [31:0] mem_rdata, int_ext_cause;
  scarv_soc_intc #(.NUM_SRC(N)) dut (
    .f_clk(f_clk), .g_reset(g_reset), .src(src),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata), .int_ext(int_ext), .int_ext_cause(int_ext_cause)
  );
  always #5 f_clk = ~f_clk;
  typedef struct { bit err; logic [31:0] data; } resp_t;
  resp_t q[$];
  int passes = 0, total = 0, ack_mode = 0;
  bit started = 0;
  bit [N-1:0] m_pend, m_en, m_mode, m_srcq, np, ne, nm;
  bit m_recv, m_int, gnt, acc, clr;
  int m_cause, win, off;
  resp_t r;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask
  // reference model: each bit evaluated from the rules, all next values from pre-edge state
  always @(posedge f_clk) begin
    if (g_reset) begin
      m_pend = '0; m_en = '0; m_mode = '1; m_srcq = '0;
      m_recv = 0; m_int = 0; m_cause = 0;
      q.delete();
      started = 1;
    end else begin
      win = -1;
      for (int i = 0; i < N; i++) if (win < 0 && m_pend[i] && m_en[i]) win = i;
      gnt = !m_recv || mem_ack;
      acc = mem_req && gnt;
      off = int'(mem_addr[4:2]);
      ne = m_en; nm = m_mode;
      for (int i = 0; i < N; i++) begin
        if (m_mode[i]) begin
          clr = (acc && mem_wen && off == 0 && mem_wdata[i] && mem_strb[i/8]) ||
                (acc && !mem_wen && off == 3 && win == i);
          np[i] = (src[i] && !m_srcq[i]) ? 1'b1 : clr ? 1'b0 : m_pend[i];
        end else np[i] = src[i];
      end
      if (acc) begin
        r.err = off >= 4;
        r.data = 0;
        if (off < 4 && mem_wen)
          for (int i = 0; i < N; i++) if (mem_strb[i/8]) begin
            if (off == 1) ne[i] = mem_wdata[i];
            if (off == 2) nm[i] = mem_wdata[i];
          end
        if (off < 4 && !mem_wen) begin
          if (off == 0) r.data = 32'(m_pend);
          else if (off == 1) r.data = 32'(m_en);
          else if (off == 2) r.data = 32'(m_mode);
          else r.data = win < 0 ? 32'hFFFF_FFFF : win;
        end
        q.push_back(r);
      end
      m_int = win >= 0;
      m_cause = win < 0 ? 0 : win;
      m_recv = acc ? 1'b1 : mem_ack ? 1'b0 : m_recv;
      m_pend = np; m_en = ne; m_mode = nm; m_srcq = src;
    end
  end
  always @(negedge f_clk) if (started) begin
    chk("int_ext", 32'(int_ext), 32'(m_int));
    chk("int_ext_cause", int_ext_cause, m_cause);
    chk("mem_gnt", 32'(mem_gnt), 32'(!m_recv || mem_ack));
    chk("mem_recv", 32'(mem_recv), 32'(m_recv));
    if (mem_recv) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL resp_unexpected: recv=1 with no response outstanding, rdata %h", mem_rdata);
      end else begin
        chk("mem_error", 32'(mem_error), 32'(q[0].err));
        chk("mem_rdata", mem_rdata, q[0].data);
        if (mem_ack) void'(q.pop_front());
      end
    end
  end
  initial forever begin
    @(posedge f_clk); #2;
    mem_ack = ack_mode == 1 ? 1'($urandom) : ack_mode == 0;
  end
  task automatic tick();
    @(posedge f_clk); #2;
  endtask
  task automatic bus_op(input bit wen, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    bit g;
    int n = 0;
    mem_req = 1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata; mem_strb = strb;
    do begin #2; g = mem_gnt; tick(); n++; end while (!g && n < 50);
    mem_req = 0;
    if (!g) begin
      total++;
      $display("FAIL bus_timeout: gnt %b after %0d cycles, required 1", g, n);
    end
  endtask
  task automatic rd(input logic [31:0] a); bus_op(0, a, 32'h0, 4'h0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); bus_op(1, a, d, 4'hF); endtask
  initial begin
    repeat (3) tick();
    g_reset = 0;
    rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
    wr(32'h4, 32'h0C);
    src[3] = 1; tick(); src[3] = 0;
    repeat (4) tick();
    rd(32'h0); rd(32'hC);
    repeat (3) tick();
    wr(32'h4, 32'hFF);
    src = 8'h24; tick(); src = '0;
    repeat (3) tick();
    rd(32'hC); rd(32'hC); rd(32'hC);
    wr(32'h8, 32'h00);
    src[1] = 1;
    repeat (4) tick();
    wr(32'h0, 32'h02); rd(32'hC); rd(32'h0);
    repeat (4) tick();
    src[1] = 0;
    repeat (3) tick();
    wr(32'h8, 32'hFF);
    src[4] = 1; tick(); src[4] = 0;
    repeat (2) tick();
    src[4] = 1;
    wr(32'h0, 32'h10);
    src[4] = 0;
    rd(32'h0);
    wr(32'h4, 32'h0);
    bus_op(1, 32'h4, 32'hFFFF_FFFF, 4'b0001);
    rd(32'h4);
    bus_op(1, 32'hC, 32'hFFFF_FFFF, 4'hF);
    ack_mode = 2;
    repeat (2) tick();
    rd(32'h14);
    repeat (5) tick();
    g_reset = 1; tick(); g_reset = 0;
    ack_mode = 0;
    repeat (2) tick();
    ack_mode = 1;
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) src = src ^ N'($urandom & $urandom);
      if ($urandom_range(0, 299) == 0) begin
        g_reset = 1; tick(); g_reset = 0;
      end else if ($urandom_range(0, 1) == 0)
        bus_op(1'($urandom), 32'($urandom_range(0, 7)) << 2, $urandom, 4'($urandom));
      else tick();
    end
    ack_mode = 0;
    repeat (5) tick();
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
